// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO stream reader: FSM state encoding and skid occupancy.
package fifo_rd_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } rd_state_e;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order skid buffer; head entry is presented on head, clear drops everything.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output occ_t              occ,
    output logic [DATA_W-1:0] head
);

    occ_t              occ_q;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;

    // Storage update; a simultaneous push and pop keeps occupancy and preserves order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else if (clear) begin
            occ_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == occ_t'(0)) begin
                        head_q <= din;
                    end else begin
                        tail_q <= din;
                    end
                    occ_q <= occ_q + occ_t'(1);
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - occ_t'(1);
                end
                2'b11: begin
                    if (occ_q == occ_t'(SKID_DEPTH)) begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end else begin
                        head_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream, hiding the FIFO read latency
// behind a 2-entry skid buffer, with a flush that discards all pending data.
// Optional feature macro: FIFO_RD_STATS_EN adds the rd_count delivered-beat counter.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = 8
`ifdef FIFO_RD_STATS_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic              busy
`ifdef FIFO_RD_STATS_EN
    , output logic [CNT_W-1:0] rd_count
`endif
);

    rd_state_e state_q;
    rd_state_e state_d;
    logic      inflight_q;
    logic      flush_armed_q;
    occ_t      occ;
    logic      flush_req;
    logic      push;
    logic      pop;
    logic      clear;
    logic [2:0] pending;

    // A flush held high across DONE must go low once before it is honoured again.
    assign flush_req = flush && flush_armed_q;

    // Next state and decoded outputs. The read gate credits a same-cycle pop so that
    // a full pipeline (occ=1, inflight=1) keeps reading and sustains one beat per cycle.
    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        m_valid    = 1'b0;
        busy       = 1'b0;
        flush_done = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        clear      = 1'b0;
        pending    = 3'(occ) + 3'(inflight_q);
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    clear   = 1'b1;
                end else if (!fifo_empty) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                busy       = 1'b1;
                m_valid    = (occ != occ_t'(0));
                pop        = m_valid && m_ready;
                push       = inflight_q;
                fifo_rd_en = !fifo_empty && (pending < 3'(SKID_DEPTH) + 3'(pop));
                if (flush_req) begin
                    state_d = FLUSH;
                    clear   = 1'b1;
                end else if (occ == occ_t'(0) && !inflight_q && fifo_empty) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                busy       = 1'b1;
                fifo_rd_en = !fifo_empty;
                if (fifo_empty && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, outstanding-read tracker and flush re-arm flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            inflight_q    <= 1'b0;
            flush_armed_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            if (clear) begin
                flush_armed_q <= 1'b0;
            end else if (!flush) begin
                flush_armed_q <= 1'b1;
            end
        end
    end

    fifo_rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (fifo_dout),
        .occ   (occ),
        .head  (m_data)
    );

`ifdef FIFO_RD_STATS_EN
    // Delivered-beat counter; wraps, survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + CNT_W'(1);
        end
    end
`endif

endmodule
